// File: rtl/sd_cmd_tx_seq.sv
// ============================================================================
// Module      : sd_cmd_tx_seq
// Description : Serialises one 48-bit SD command frame (start, index, argument,
//               CRC7, end bit) onto the CMD line, one bit per CE tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_cmd_tx_seq #(
    parameter int PREAMBLE = 2,
    parameter int CNT_W    = 6
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        CMD_VALID,
    input  logic [5:0]  CMD_IDX,
    input  logic [31:0] CMD_ARG,
    input  logic        ABORT,
    output logic        CMD_READY,
    output logic        CMD_OUT,
    output logic        CMD_OE,
    output logic        DONE,
    output logic [6:0]  CRC_OUT
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_CRC  = 3'd3,
        ST_ENDB = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(39);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(6);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [39:0]        sreg, sreg_n;
    logic [6:0]         crc, crc_n, crc_upd, crc_out_n;
    logic               out_n, oe_n, done_n;
    logic               inv;

    // CRC7 (x^7 + x^3 + 1) advanced by the bit currently leaving the shifter
    assign inv     = sreg[39] ^ crc[6];
    assign crc_upd = {crc[5:3], crc[2] ^ inv, crc[1:0], inv};

    assign CMD_READY = (state == ST_IDLE);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sreg_n    = sreg;
        crc_n     = crc;
        out_n     = CMD_OUT;
        oe_n      = CMD_OE;
        done_n    = 1'b0;
        crc_out_n = CRC_OUT;

        if (state == ST_IDLE) begin
            if (CMD_VALID) begin
                sreg_n  = {1'b0, 1'b1, CMD_IDX, CMD_ARG};
                crc_n   = '0;
                cnt_n   = '0;
                state_n = (PREAMBLE > 0) ? ST_PRE : ST_DATA;
            end
        end else if (ABORT) begin
            state_n = ST_IDLE;
            oe_n    = 1'b0;
            out_n   = 1'b1;
        end else if (CE) begin
            case (state)
                ST_PRE: begin
                    out_n = 1'b1;
                    oe_n  = 1'b1;
                    if (cnt == PRE_LAST) begin
                        cnt_n   = '0;
                        state_n = ST_DATA;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    out_n  = sreg[39];
                    oe_n   = 1'b1;
                    crc_n  = crc_upd;
                    sreg_n = {sreg[38:0], 1'b0};
                    if (cnt == DATA_LAST) begin
                        cnt_n     = '0;
                        state_n   = ST_CRC;
                        crc_out_n = crc_upd;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_CRC: begin
                    // CRC is emitted MSB-first as a plain shift, no feedback
                    out_n = crc[6];
                    crc_n = {crc[5:0], 1'b0};
                    if (cnt == CRC_LAST) begin
                        cnt_n   = '0;
                        state_n = ST_ENDB;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_ENDB: begin
                    out_n   = 1'b1;
                    state_n = ST_FIN;
                end
                ST_FIN: begin
                    oe_n    = 1'b0;
                    out_n   = 1'b1;
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            sreg    <= '0;
            crc     <= '0;
            CMD_OUT <= 1'b1;
            CMD_OE  <= 1'b0;
            DONE    <= 1'b0;
            CRC_OUT <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sreg    <= sreg_n;
            crc     <= crc_n;
            CMD_OUT <= out_n;
            CMD_OE  <= oe_n;
            DONE    <= done_n;
            CRC_OUT <= crc_out_n;
        end
    end

endmodule

`default_nettype wire
